audio_top: RTL and testbench
============================

AUDIO_TOP -- requirements
Module: audio_top

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset; all state changes on the rising edge of clk.
REQ-002 Port clk, input, 1 bit: system clock, nominal 28.375 MHz.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port exchan, input, 1 bit: 1 = swap the left and right channels.
REQ-005 Port mix, input, 1 bit: 1 = centred cross-mix.
REQ-006 Port ldata, input, 16 bits: left sample, two's complement.
REQ-007 Port rdata, input, 16 bits: right sample, two's complement.
REQ-008 Port aud_xck, output, 1 bit: codec master clock.
REQ-009 Port aud_bclk, output, 1 bit: codec bit clock.
REQ-010 Port aud_daclrck, output, 1 bit: codec DAC left/right clock.
REQ-011 Port aud_dacdat, output, 1 bit: codec serial data.
REQ-012 Port i2c_sclk, output, 1 bit: codec configuration clock, push-pull.
REQ-013 Port i2c_sdat, inout, 1 bit: codec configuration data, open-drain; the block drives only 0 or Z.

Function
REQ-014 A 9-bit free-running counter cnt SHALL increment by 1 every clk and wrap from 0x1FF to 0x000.
REQ-015 The codec clocks SHALL be derived from cnt as follows:
- aud_xck = cnt[0] (clk/2).
- aud_bclk = cnt[3] (clk/16).
- aud_daclrck = ~cnt[8] (clk/512, about 55.4 kHz).
- Result: 16 bit-clocks per channel half-frame.
REQ-016 Half-frame assignment: cnt[8]=0 is the left half (aud_daclrck=1); cnt[8]=1 is the right half.
REQ-017 On the clk edge where cnt==0x1FF, holding registers hold_l and hold_r SHALL capture the processed samples; each capture is used for the next full frame.
REQ-018 Processing order: when exchan=1, swap first (a=rdata, b=ldata; otherwise a=ldata, b=rdata); then apply mix.
REQ-019 With mix=0: out_l = a, out_r = b.
REQ-020 With mix=1: out_l = a - (a>>>2) + (b>>>2), and out_r = b - (b>>>2) + (a>>>2).
- Arithmetic shift, 17-bit signed intermediate, truncated to 16 bits.
- The result cannot overflow.
REQ-021 Serial format is left-justified, MSB first, with the MSB aligned to the aud_daclrck edge.
REQ-022 aud_dacdat SHALL equal bit [15 - cnt[7:4]] of hold_l when cnt[8]=0, or of hold_r when cnt[8]=1.
- Data changes only when cnt[3:0]=0, i.e. on the aud_bclk falling edge.
- The codec samples on the aud_bclk rising edge.
REQ-023 The I2C master SHALL write 8 configuration words once after reset, in this order, to device address 0x34 (write):
- 0x1E00, 0x0C00, 0x0812, 0x0A00
- 0x0E01 (left-justified, 16-bit, slave), 0x1000, 0x0579, 0x1201 (active)
REQ-024 I2C timing uses a quarter-bit tick every 64 clk, giving an SCL period of 256 clk (about 111 kHz).
REQ-025 Each word transaction SHALL run in this order:
- START: SDA falls while SCL=1.
- Address byte 0x34, then word[15:8], then word[7:0]; each bit is MSB first, SDA changes only while SCL=0.
- After each byte, one ACK clock with SDA released.
- STOP: SDA rises while SCL=1.
- Idle gap of 4 ticks before the next word.
REQ-026 The ACK bit SHALL be ignored: no retry and no abort.
REQ-027 After the 8th word the FSM SHALL stay in DONE with i2c_sclk=1 and i2c_sdat=Z until rst.
REQ-028 FSM states:
- IDLE: wait 1 tick after reset, then go to START.
- START, BIT (4 ticks per bit), ACK, STOP, GAP.
- GAP goes back to START, or to DONE after word 8.
REQ-029 The I2S and I2C paths SHALL run independently; the I2S output runs during configuration.

Reset
REQ-030 While rst=1 and on the first edge after it, the block SHALL hold these values:
- cnt=0, hold_l=hold_r=0.
- aud_xck=0, aud_bclk=0, aud_daclrck=1, aud_dacdat=0.
- i2c_sclk=1, i2c_sdat=Z, FSM=IDLE, word index=0.
REQ-031 Asserting rst mid-frame or mid-transaction SHALL abort at once to the reset values; the configuration sequence then restarts from word 0.

Verification
REQ-032 Clock ratios: release rst and run 1024 clk. Required response:
- aud_xck toggles every clk.
- aud_bclk period is 16 clk.
- aud_daclrck period is 512 clk and goes 1->0 at cnt 0x100.
REQ-033 Serial data: ldata=0x8001, rdata=0x7FFE, exchan=0, mix=0. In the second frame:
- Left half serialises 1000000000000001.
- Right half serialises 0111111111111110, MSB at the aud_daclrck edge.
REQ-034 Swap: exchan=1 with the same data. Left half carries 0x7FFE and right half carries 0x8001.
REQ-035 Mix: mix=1, ldata=0x4000, rdata=0x0000. Left half carries 0x3000 and right half carries 0x1000.
REQ-036 Configuration bus: decode the bus after reset. Required response:
- 8 transactions, each with START, 0x34, then the word bytes in REQ-023 order, then STOP.
- SDA is never driven high.
- Bus idle in DONE.
REQ-037 Reset mid-operation: assert rst during word 3 bit 5. Outputs return to reset values the next clk, and after release decoding restarts with word 0x1E00.

Source files
------------

// File: rtl/audio_top.sv
// Codec front end: left-justified 16-bit DAC serialiser driven from a free-running
// divider, plus a one-shot I2C master that writes the codec setup after reset.
module audio_top (
    input  logic        clk,
    input  logic        rst,
    input  logic        exchan,
    input  logic        mix,
    input  logic [15:0] ldata,
    input  logic [15:0] rdata,
    output logic        aud_xck,
    output logic        aud_bclk,
    output logic        aud_daclrck,
    output logic        aud_dacdat,
    output logic        i2c_sclk,
    inout  wire         i2c_sdat
);

    // ------------------------------------------------------------------
    // Sample path and serialiser
    // ------------------------------------------------------------------
    logic [8:0]         cnt;
    logic [15:0]        hold_l;
    logic [15:0]        hold_r;
    logic [15:0]        a;
    logic [15:0]        b;
    logic signed [15:0] a_s;
    logic signed [15:0] b_s;
    logic signed [15:0] mix_l;
    logic signed [15:0] mix_r;
    logic [15:0]        out_l;
    logic [15:0]        out_r;
    logic [3:0]         bit_sel;

    // NOTE: every signal written in always_comb gets a value first, so no path can infer a latch.
    always_comb begin
        a     = exchan ? rdata : ldata;
        b     = exchan ? ldata : rdata;
        a_s   = a;
        b_s   = b;
        // Arithmetic in 16 bits wraps exactly like a truncated 17-bit intermediate.
        mix_l = a_s - (a_s >>> 2) + (b_s >>> 2);
        mix_r = b_s - (b_s >>> 2) + (a_s >>> 2);
        out_l = mix ? mix_l : a;
        out_r = mix ? mix_r : b;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 9'd0;
            hold_l <= 16'd0;
            hold_r <= 16'd0;
        end else begin
            cnt <= cnt + 9'd1;
            if (cnt == 9'h1FF) begin
                hold_l <= out_l;
                hold_r <= out_r;
            end
        end
    end

    assign bit_sel     = 4'd15 - cnt[7:4];
    assign aud_xck     = cnt[0];
    assign aud_bclk    = cnt[3];
    assign aud_daclrck = ~cnt[8];
    assign aud_dacdat  = cnt[8] ? hold_r[bit_sel] : hold_l[bit_sel];

    // ------------------------------------------------------------------
    // I2C configuration master
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_GAP,
        S_DONE
    } i2c_state_t;

    i2c_state_t state;
    i2c_state_t state_nxt;
    logic [5:0] tick_div;
    logic       tick;
    logic [1:0] phase;
    logic [1:0] phase_nxt;
    logic [2:0] bit_idx;
    logic [2:0] bit_idx_nxt;
    logic [1:0] byte_idx;
    logic [1:0] byte_idx_nxt;
    logic [2:0] word_idx;
    logic [2:0] word_idx_nxt;
    logic [15:0] word;
    logic [7:0] cur_byte;
    logic       scl_c;
    logic       sda_low_c;
    logic       scl_q;
    logic       sda_low_q;

    assign tick = (tick_div == 6'd63);

    always_comb begin
        word = 16'h0000;
        case (word_idx)
            3'd0: word = 16'h1E00;
            3'd1: word = 16'h0C00;
            3'd2: word = 16'h0812;
            3'd3: word = 16'h0A00;
            3'd4: word = 16'h0E01;
            3'd5: word = 16'h1000;
            3'd6: word = 16'h0579;
            3'd7: word = 16'h1201;
            default: word = 16'h0000;
        endcase
    end

    always_comb begin
        cur_byte = word[7:0];
        case (byte_idx)
            2'd0:    cur_byte = 8'h34;
            2'd1:    cur_byte = word[15:8];
            default: cur_byte = word[7:0];
        endcase
    end

    // Each bit, ACK and bus condition spans four quarter-bit ticks; SCL is high in
    // quarters 1 and 2 of a clock, so SDA is only ever moved in quarter 0.
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        bit_idx_nxt  = bit_idx;
        byte_idx_nxt = byte_idx;
        word_idx_nxt = word_idx;
        scl_c        = 1'b1;
        sda_low_c    = 1'b0;

        if (tick && state != S_IDLE && state != S_DONE) begin
            phase_nxt = phase + 2'd1;
        end

        case (state)
            S_IDLE: begin
                if (tick) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                scl_c     = (phase != 2'd3);
                sda_low_c = (phase != 2'd0);
                if (tick && phase == 2'd3) begin
                    state_nxt    = S_BIT;
                    bit_idx_nxt  = 3'd0;
                    byte_idx_nxt = 2'd0;
                end
            end
            S_BIT: begin
                scl_c     = (phase == 2'd1) || (phase == 2'd2);
                sda_low_c = ~cur_byte[3'd7 - bit_idx];
                if (tick && phase == 2'd3) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_ACK;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            S_ACK: begin
                scl_c = (phase == 2'd1) || (phase == 2'd2);
                if (tick && phase == 2'd3) begin
                    if (byte_idx == 2'd2) begin
                        state_nxt = S_STOP;
                    end else begin
                        state_nxt    = S_BIT;
                        byte_idx_nxt = byte_idx + 2'd1;
                        bit_idx_nxt  = 3'd0;
                    end
                end
            end
            S_STOP: begin
                scl_c     = (phase != 2'd0);
                sda_low_c = (phase == 2'd0) || (phase == 2'd1);
                if (tick && phase == 2'd3) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (tick && phase == 2'd3) begin
                    if (word_idx == 3'd7) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt    = S_START;
                        word_idx_nxt = word_idx + 3'd1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tick_div  <= 6'd0;
            phase     <= 2'd0;
            bit_idx   <= 3'd0;
            byte_idx  <= 2'd0;
            word_idx  <= 3'd0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_div  <= tick_div + 6'd1;
            phase     <= phase_nxt;
            bit_idx   <= bit_idx_nxt;
            byte_idx  <= byte_idx_nxt;
            word_idx  <= word_idx_nxt;
            // Registered pins keep decode glitches off the bus.
            scl_q     <= scl_c;
            sda_low_q <= sda_low_c;
        end
    end

    assign i2c_sclk = scl_q;
    assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_audio_top.sv
// Directed bench for audio_top: codec clock ratios, serial frames for several
// channel/mix settings, I2C configuration decode, and reset mid-transaction.
module tb_audio_top;

    logic        clk;
    logic        rst;
    logic        exchan;
    logic        mix;
    logic [15:0] ldata;
    logic [15:0] rdata;
    logic        aud_xck;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;
    logic        i2c_sclk;
    tri1         i2c_sdat;

    audio_top dut (
        .clk         (clk),
        .rst         (rst),
        .exchan      (exchan),
        .mix         (mix),
        .ldata       (ldata),
        .rdata       (rdata),
        .aud_xck     (aud_xck),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat),
        .i2c_sclk    (i2c_sclk),
        .i2c_sdat    (i2c_sdat)
    );

    localparam logic [15:0] CFG_WORDS [8] = '{
        16'h1E00, 16'h0C00, 16'h0812, 16'h0A00,
        16'h0E01, 16'h1000, 16'h0579, 16'h1201
    };

    int         n_total = 0;
    int         n_bad   = 0;
    logic [8:0] m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; m_cnt tracks the expected divider value seen at the following negedge.
    task automatic step();
        @(posedge clk);
        m_cnt = rst ? 9'd0 : m_cnt + 9'd1;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " xck"},    aud_xck,     1'b0);
        check({tag, " bclk"},   aud_bclk,    1'b0);
        check({tag, " lrck"},   aud_daclrck, 1'b1);
        check({tag, " dacdat"}, aud_dacdat,  1'b0);
        check({tag, " sclk"},   i2c_sclk,    1'b1);
        check({tag, " sdat"},   i2c_sdat,    1'b1);
    endtask

    // Waits for the frame boundary, then shifts out one full frame at the bclk rising point.
    task automatic capture_frame(output logic [15:0] fl, output logic [15:0] fr, output int glitch);
        logic pd;
        fl = 16'h0000;
        fr = 16'h0000;
        glitch = 0;
        for (int i = 0; i < 512 && m_cnt != 9'h1FF; i++) step();
        pd = aud_dacdat;
        for (int i = 0; i < 512; i++) begin
            step();
            if (m_cnt[3:0] != 4'd0 && aud_dacdat !== pd) glitch++;
            if (aud_daclrck !== ~m_cnt[8]) glitch++;
            if (m_cnt[3:0] == 4'd8) begin
                if (!m_cnt[8]) fl[4'd15 - m_cnt[7:4]] = aud_dacdat;
                else           fr[4'd15 - m_cnt[7:4]] = aud_dacdat;
            end
            pd = aud_dacdat;
        end
    endtask

    task automatic run_vec(input string tag, input logic x, input logic m,
                           input logic [15:0] l, input logic [15:0] r,
                           input logic [15:0] el, input logic [15:0] er);
        logic [15:0] gl;
        logic [15:0] gr;
        int          gb;
        exchan = x;
        mix    = m;
        ldata  = l;
        rdata  = r;
        capture_frame(gl, gr, gb);
        capture_frame(gl, gr, gb);
        check({tag, " left"},  gl, el);
        check({tag, " right"}, gr, er);
        check({tag, " edges"}, gb, 0);
    endtask

    // I2C bus decoder: START/STOP detection, byte assembly on SCL rise, word compare at STOP.
    int         mon_word;
    int         mon_bits;
    int         mon_nbytes;
    int         mon_bitcnt;
    logic       mon_in_txn;
    logic [7:0] mon_shreg;
    logic [7:0] mon_bytes [3];
    logic       prev_scl;
    logic       prev_sda;

    initial begin
        mon_word = 0; mon_bits = 0; mon_nbytes = 0; mon_bitcnt = 0;
        mon_in_txn = 1'b0; mon_shreg = 8'h00;
        prev_scl = 1'b1; prev_sda = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_word = 0; mon_bits = 0; mon_nbytes = 0; mon_bitcnt = 0;
                mon_in_txn = 1'b0;
            end else if (prev_scl && i2c_sclk && prev_sda && !i2c_sdat) begin
                mon_in_txn = 1'b1; mon_bits = 0; mon_nbytes = 0; mon_bitcnt = 0;
            end else if (prev_scl && i2c_sclk && !prev_sda && i2c_sdat) begin
                if (mon_in_txn) begin
                    check("i2c byte count", mon_nbytes, 3);
                    if (mon_word < 8) begin
                        check("i2c addr", mon_bytes[0], 8'h34);
                        check("i2c word hi", mon_bytes[1], CFG_WORDS[mon_word][15:8]);
                        check("i2c word lo", mon_bytes[2], CFG_WORDS[mon_word][7:0]);
                    end else begin
                        check("i2c extra txn", mon_word, 7);
                    end
                    mon_word++;
                end
                mon_in_txn = 1'b0;
                mon_bits = 0;
            end else if (!prev_scl && i2c_sclk && mon_in_txn) begin
                mon_bits++;
                if (mon_bitcnt < 8) begin
                    mon_shreg = {mon_shreg[6:0], i2c_sdat};
                    mon_bitcnt++;
                end else begin
                    check("i2c ack released", i2c_sdat, 1'b1);
                    if (mon_nbytes < 3) mon_bytes[mon_nbytes] = mon_shreg;
                    mon_nbytes++;
                    mon_bitcnt = 0;
                end
            end
            prev_scl = i2c_sclk;
            prev_sda = i2c_sdat;
        end
    end

    int   xck_bad, bclk_rise, bclk_bad, lr_fall, lr_bad, idle_bad;
    logic p_xck, p_bclk, p_lr;

    initial begin
        rst = 1'b1; exchan = 1'b0; mix = 1'b0; ldata = 16'h0000; rdata = 16'h0000;
        m_cnt = 9'd0;
        repeat (3) step();
        check_reset_values("reset");
        rst = 1'b0;

        xck_bad = 0; bclk_rise = 0; bclk_bad = 0; lr_fall = 0; lr_bad = 0;
        p_xck = aud_xck; p_bclk = aud_bclk; p_lr = aud_daclrck;
        for (int i = 0; i < 1024; i++) begin
            step();
            if (aud_xck === p_xck) xck_bad++;
            if (aud_bclk && !p_bclk) bclk_rise++;
            if (aud_bclk !== m_cnt[3]) bclk_bad++;
            if (!aud_daclrck && p_lr) begin
                lr_fall++;
                if (m_cnt != 9'h100) lr_bad++;
            end
            if (aud_daclrck !== ~m_cnt[8]) lr_bad++;
            p_xck = aud_xck; p_bclk = aud_bclk; p_lr = aud_daclrck;
        end
        check("xck toggles", xck_bad, 0);
        check("bclk rises", bclk_rise, 64);
        check("bclk phase", bclk_bad, 0);
        check("lrck falls", lr_fall, 2);
        check("lrck phase", lr_bad, 0);

        run_vec("straight",  1'b0, 1'b0, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE);
        run_vec("swap",      1'b1, 1'b0, 16'h8001, 16'h7FFE, 16'h7FFE, 16'h8001);
        run_vec("mix",       1'b0, 1'b1, 16'h4000, 16'h0000, 16'h3000, 16'h1000);
        run_vec("mix swap",  1'b1, 1'b1, 16'h4000, 16'h0000, 16'h1000, 16'h3000);
        run_vec("mix full",  1'b0, 1'b1, 16'h8000, 16'h7FFF, 16'hBFFF, 16'h4000);
        run_vec("mix neg",   1'b0, 1'b1, 16'hFFFF, 16'h0004, 16'h0001, 16'h0002);

        for (int i = 0; i < 20000 && !(mon_word == 2 && mon_bits >= 5); i++) step();
        check("reach word 3 bit 5", mon_word, 2);
        rst = 1'b1;
        step();
        check_reset_values("mid reset");
        repeat (4) step();
        rst = 1'b0;

        for (int i = 0; i < 64000 && mon_word < 8; i++) step();
        check("cfg words decoded", mon_word, 8);

        idle_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (i2c_sclk !== 1'b1 || i2c_sdat !== 1'b1) idle_bad++;
        end
        check("bus idle in done", idle_bad, 0);
        check("no txn after done", mon_word, 8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
